// File: rtl/fas_serial_seq.sv
`default_nettype none
// ============================================================================
//  Module      : fas_serial_seq
//  Description : Bit-serial WIDTH-bit adder/subtractor sequencer. One operand
//                bit pair per clock (LSB first) through a single full
//                adder/subtractor cell; carry/borrow fed back each cycle.
//                start/busy/done handshake towards the host side.
//  Option      : define FAS_SIGNED_OVF_EN to add the two's-complement
//                overflow output ovf.
//  Revision    : 1.0 - initial release
// ============================================================================
module fas_serial_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             a_ns,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout
`ifdef FAS_SIGNED_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int                CNT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0]  C_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;        // operand A, shifted right so bit k sits at [0]
  logic [WIDTH-1:0] r_b;        // operand B, shifted the same way
  logic [WIDTH-1:0] r_result;
  logic [CNT_W-1:0] r_cnt;
  logic             r_add;
  logic             r_c;        // carry (add) or borrow (subtract)
  logic             r_busy;
  logic             r_done;
  logic             r_cout;

  logic             w_abit;
  logic             w_bbit;
  logic             w_ax;
  logic             w_s;
  logic             w_cnext;

  // Bit cell: subtraction reuses the carry equation with A inverted.
  assign w_abit  = r_a[0];
  assign w_bbit  = r_b[0];
  assign w_ax    = r_add ? w_abit : ~w_abit;
  assign w_s     = w_abit ^ w_bbit ^ r_c;
  assign w_cnext = (w_ax & w_bbit) | (w_ax & r_c) | (w_bbit & r_c);

`ifdef FAS_SIGNED_OVF_EN
  logic r_ovf;
  logic w_ovf;
  // On the last bit the cell already sees the operand MSBs, so no separate
  // MSB capture is needed.
  assign w_ovf = r_add ? ((w_abit == w_bbit) && (w_s != w_abit))
                       : ((w_abit != w_bbit) && (w_s != w_abit));
  assign ovf   = r_ovf;
`endif

  // Sequencer FSM: accept, shift one bit per cycle, pulse done.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_cnt    <= '0;
      r_add    <= 1'b0;
      r_c      <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_cout   <= 1'b0;
`ifdef FAS_SIGNED_OVF_EN
      r_ovf    <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a     <= op_a;
            r_b     <= op_b;
            r_add   <= a_ns;
            r_c     <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_result <= {w_s, r_result[WIDTH-1:1]};
          r_a      <= {1'b0, r_a[WIDTH-1:1]};
          r_b      <= {1'b0, r_b[WIDTH-1:1]};
          r_c      <= w_cnext;
          r_cnt    <= r_cnt + 1'b1;
          if (r_cnt == C_LAST) begin
            r_cout  <= w_cnext;
`ifdef FAS_SIGNED_OVF_EN
            r_ovf   <= w_ovf;
`endif
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;
  assign cout   = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_fas_serial_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fas_serial_seq
//  Description : Self-checking bench for fas_serial_seq (WIDTH=8). Expected
//                results are queued when an operation is launched and popped
//                when done is observed. Honours FAS_SIGNED_OVF_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fas_serial_seq;

  localparam int WIDTH = 8;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             co;
    logic             ov;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             a_ns = 1'b0;
  logic [WIDTH-1:0] op_a = '0;
  logic [WIDTH-1:0] op_b = '0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
`ifdef FAS_SIGNED_OVF_EN
  logic             ovf;
`endif

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];

  fas_serial_seq #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a_ns   (a_ns),
    .op_a   (op_a),
    .op_b   (op_b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout)
`ifdef FAS_SIGNED_OVF_EN
    ,
    .ovf    (ovf)
`endif
  );

  always #5 clk = ~clk;

  // Reference arithmetic on whole words, independent of the bit-serial cell.
  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic add);
    logic [WIDTH:0] t;
    exp_t e;
    t = add ? ({1'b0, a} + {1'b0, b}) : ({1'b0, a} - {1'b0, b});
    e.res = t[WIDTH-1:0];
    e.co  = t[WIDTH];
    if (add) e.ov = (a[WIDTH-1] == b[WIDTH-1]) && (e.res[WIDTH-1] != a[WIDTH-1]);
    else     e.ov = (a[WIDTH-1] != b[WIDTH-1]) && (e.res[WIDTH-1] != a[WIDTH-1]);
    return e;
  endfunction

  // busy and done must never be high together.
  always @(negedge clk) begin
    if (rst_n) begin
      n_checks++;
      if (busy && done) begin
        n_errors++;
        $display("FAIL busy_done_overlap: busy=%b done=%b required not both 1", busy, done);
      end
    end
  end

  // Launch one operation once the DUT is idle and watch it to done (stimulus only).
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic add, output int lat, output int bc, output bit got);
    int guard;
    guard = 0;
    @(negedge clk);
    while ((busy || done) && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    start = 1'b1; op_a = a; op_b = b; a_ns = add;
    lat = 0; bc = 0; got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 0) begin
        // Scramble inputs to show they were latched at acceptance.
        start = 1'b0; op_a = ~a; op_b = ~b; a_ns = ~add;
      end
      lat++;
      if (busy) bc++;
      if (done) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL reset_done: got %b want 0", done); end
    n_checks++; if (result !== '0) begin n_errors++; $display("FAIL reset_result: got %h want 00", result); end
    n_checks++; if (cout !== 1'b0) begin n_errors++; $display("FAIL reset_cout: got %b want 0", cout); end
`ifdef FAS_SIGNED_OVF_EN
    n_checks++; if (ovf !== 1'b0) begin n_errors++; $display("FAIL reset_ovf: got %b want 0", ovf); end
`endif
    rst_n = 1'b1;
  endtask

  task automatic test_arith();
    logic [WIDTH-1:0] ta [12];
    logic [WIDTH-1:0] tb [12];
    logic             tadd [12];
    exp_t             texp [12];
    exp_t             e;
    int lat, bc;
    bit got;
    // Directed cases with hand-derived expectations, then model-checked random ones.
    ta[0] = 8'h5A; tb[0] = 8'h33; tadd[0] = 1; texp[0] = '{res: 8'h8D, co: 1'b0, ov: 1'b1};
    ta[1] = 8'hFF; tb[1] = 8'h01; tadd[1] = 1; texp[1] = '{res: 8'h00, co: 1'b1, ov: 1'b0};
    ta[2] = 8'h7F; tb[2] = 8'h01; tadd[2] = 1; texp[2] = '{res: 8'h80, co: 1'b0, ov: 1'b1};
    ta[3] = 8'h10; tb[3] = 8'h01; tadd[3] = 0; texp[3] = '{res: 8'h0F, co: 1'b0, ov: 1'b0};
    ta[4] = 8'h00; tb[4] = 8'h01; tadd[4] = 0; texp[4] = '{res: 8'hFF, co: 1'b1, ov: 1'b0};
    ta[5] = 8'h80; tb[5] = 8'h01; tadd[5] = 0; texp[5] = '{res: 8'h7F, co: 1'b0, ov: 1'b1};
    for (int i = 6; i < 12; i++) begin
      ta[i] = WIDTH'($urandom); tb[i] = WIDTH'($urandom); tadd[i] = 1'(i & 1);
      texp[i] = model(ta[i], tb[i], tadd[i]);
    end
    for (int i = 0; i < 12; i++) begin
      sb.push_back(texp[i]);
      run_op(ta[i], tb[i], tadd[i], lat, bc, got);
      n_checks++;
      if (!got) begin
        n_errors++;
        $display("FAIL arith_timeout[%0d]: done not seen, required within 40 cycles", i);
        void'(sb.pop_front());
        continue;
      end
      e = sb.pop_front();
      n_checks++; if (result !== e.res) begin n_errors++; $display("FAIL arith_result[%0d]: got %h want %h", i, result, e.res); end
      n_checks++; if (cout !== e.co) begin n_errors++; $display("FAIL arith_cout[%0d]: got %b want %b", i, cout, e.co); end
`ifdef FAS_SIGNED_OVF_EN
      n_checks++; if (ovf !== e.ov) begin n_errors++; $display("FAIL arith_ovf[%0d]: got %b want %b", i, ovf, e.ov); end
`endif
      n_checks++; if (lat != WIDTH + 1) begin n_errors++; $display("FAIL arith_latency[%0d]: got %0d want %0d", i, lat, WIDTH + 1); end
      n_checks++; if (bc != WIDTH) begin n_errors++; $display("FAIL arith_busy_cycles[%0d]: got %0d want %0d", i, bc, WIDTH); end
    end
  endtask

  task automatic test_ignore_start();
    int   dones, cyc;
    exp_t e;
    @(negedge clk);
    while (busy || done) @(negedge clk);
    sb.push_back(model(8'h20, 8'h05, 1'b1));
    start = 1'b1; op_a = 8'h20; op_b = 8'h05; a_ns = 1'b1;
    dones = 0; cyc = 0;
    while (dones == 0 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (cyc == 3) begin start = 1'b1; op_a = 8'h01; op_b = 8'h01; end
      if (done) dones++;
    end
    n_checks++;
    if (dones != 1) begin
      n_errors++;
      $display("FAIL ignore_timeout: dones=%0d want 1", dones);
    end else begin
      e = sb.pop_front();
      n_checks++; if (result !== e.res) begin n_errors++; $display("FAIL ignore_result: got %h want %h", result, e.res); end
      // Start raised during the DONE cycle must be dropped.
      start = 1'b1; op_a = 8'h01; op_b = 8'h01;
      @(negedge clk);
      start = 1'b0;
      n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL ignore_done_start: busy got %b want 0", busy); end
    end
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || busy) dones++;
    end
    n_checks++; if (dones != 0) begin n_errors++; $display("FAIL ignore_no_extra_op: active cycles got %0d want 0", dones); end
  endtask

  task automatic test_abort();
    int   lat, bc, dones;
    bit   got;
    exp_t e;
    // Leave cout=1 behind so the reset clearing it is observable.
    sb.push_back(model(8'hFF, 8'h01, 1'b1));
    run_op(8'hFF, 8'h01, 1'b1, lat, bc, got);
    e = sb.pop_front();
    n_checks++; if (!got || cout !== e.co) begin n_errors++; $display("FAIL abort_pre_cout: got %b want %b", cout, e.co); end
    @(negedge clk);
    start = 1'b1; op_a = 8'h12; op_b = 8'h34; a_ns = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL abort_running: busy got %b want 1", busy); end
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL abort_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL abort_done: got %b want 0", done); end
    n_checks++; if (result !== '0) begin n_errors++; $display("FAIL abort_result: got %h want 00", result); end
    n_checks++; if (cout !== 1'b0) begin n_errors++; $display("FAIL abort_cout: got %b want 0", cout); end
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    n_checks++; if (dones != 0) begin n_errors++; $display("FAIL abort_no_done: got %0d want 0", dones); end
    sb.push_back(model(8'h12, 8'h34, 1'b1));
    run_op(8'h12, 8'h34, 1'b1, lat, bc, got);
    e = sb.pop_front();
    n_checks++; if (!got || result !== e.res) begin n_errors++; $display("FAIL abort_recover: got %h want %h", result, e.res); end
  endtask

  task automatic test_back_to_back();
    int   cyc, ndone, last;
    exp_t e;
    @(negedge clk);
    while (busy || done) @(negedge clk);
    for (int i = 0; i < 3; i++) sb.push_back('{res: 8'hFF, co: 1'b0, ov: 1'b0});
    start = 1'b1; op_a = 8'hAA; op_b = 8'h55; a_ns = 1'b1;
    cyc = 0; ndone = 0; last = 0;
    while (ndone < 3 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        e = sb.pop_front();
        n_checks++; if (result !== e.res) begin n_errors++; $display("FAIL b2b_result[%0d]: got %h want %h", ndone, result, e.res); end
        n_checks++; if (cout !== e.co) begin n_errors++; $display("FAIL b2b_cout[%0d]: got %b want %b", ndone, cout, e.co); end
        if (ndone > 0) begin
          n_checks++;
          if (cyc - last != WIDTH + 2) begin n_errors++; $display("FAIL b2b_period[%0d]: got %0d want %0d", ndone, cyc - last, WIDTH + 2); end
        end
        last = cyc;
        ndone++;
      end
    end
    start = 1'b0;
    n_checks++; if (ndone != 3) begin n_errors++; $display("FAIL b2b_count: got %0d want 3", ndone); end
    sb.delete();
  endtask

  initial begin
    test_reset();
    test_arith();
    test_ignore_start();
    test_abort();
    test_back_to_back();
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
